// File: rtl/btn_debounce_if.sv
// ---------------------------------------------------------------------------
// btn_debounce_if
//   Groups the button-side input and the conditioned outputs of the debouncer.
//   Signal names are written from the debouncer's point of view.
//
//   i_din   raw asynchronous button level, active-high, may bounce
//   o_dout  debounced level, registered
//   o_busy  high while a candidate level change is being qualified
//   o_long  one-clock long-press pulse (always 0 unless the feature is built)
//
//   modport master : the side that owns the raw button and consumes results
//   modport slave  : the debouncer itself
// ---------------------------------------------------------------------------
interface btn_debounce_if;
    logic i_din;
    logic o_dout;
    logic o_busy;
    logic o_long;

    modport master (
        output i_din,
        input  o_dout,
        input  o_busy,
        input  o_long
    );

    modport slave (
        input  i_din,
        output o_dout,
        output o_busy,
        output o_long
    );
endinterface

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//   Turns a raw, asynchronous, bouncing push-button level into a clean level
//   synchronous to i_clk. The input passes a 2-flop synchronizer; a 4-state
//   FSM then accepts a level change only after the synchronized input has
//   held the new level for DEB_CYCLES consecutive clocks. A clean step on
//   i_din reaches o_dout DEB_CYCLES+3 edges after it is first sampled.
//   o_dout feeds the downstream edge detector.
//
// Parameters
//   DEB_CYCLES   stable clocks needed to accept a change (>= 2)
//   LONG_CYCLES  clocks the button must stay accepted-high before o_long
//                pulses (>= 1, only meaningful with the long-press build)
//
// Ports
//   i_clk    clock, rising edge
//   i_rstn   asynchronous, active-low reset
//   bus      btn_debounce_if.slave : i_din in, o_dout / o_busy / o_long out
//
// Build option
//   BTN_DEBOUNCE_LONG_PRESS_EN  when defined, adds a long-press counter that
//                               emits a single-clock o_long pulse once the
//                               button has been held for LONG_CYCLES clocks.
//                               When undefined, o_long is tied low and no
//                               counter exists.
// ---------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEB_CYCLES  = 500_000,
    parameter int LONG_CYCLES = 50_000_000
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    btn_debounce_if.slave  bus
);

    // A 1-bit counter is still needed when DEB_CYCLES is 2.
    localparam int                CNT_W   = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_CHK_HIGH = 2'd1,
        S_HIGH     = 2'd2,
        S_CHK_LOW  = 2'd3
    } state_t;

    logic             r_sync_p0;
    logic             r_sync_p1;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dout;
    logic             r_busy;

    // Synchronizer: only r_sync_p1 is ever looked at by the FSM.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
        end else begin
            r_sync_p0 <= bus.i_din;
            r_sync_p1 <= r_sync_p0;
        end
    end

    // Qualification FSM. o_busy is registered together with the state so it
    // is exactly "state is one of the S_CHK_* states".
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_dout  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_LOW: begin
                    if (r_sync_p1) begin
                        r_state <= S_CHK_HIGH;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_CHK_HIGH: begin
                    if (!r_sync_p1) begin
                        // bounce: give up, next high sample restarts from 0
                        r_state <= S_LOW;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state <= S_HIGH;
                        r_dout  <= 1'b1;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (!r_sync_p1) begin
                        r_state <= S_CHK_LOW;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_CHK_LOW: begin
                    if (r_sync_p1) begin
                        r_state <= S_HIGH;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state <= S_LOW;
                        r_dout  <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_LOW;
                    r_cnt   <= '0;
                    r_dout  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_dout = r_dout;
    assign bus.o_busy = r_busy;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    localparam int               LNG_W   = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES + 1) : 1;
    localparam logic [LNG_W-1:0] LNG_MAX = LNG_W'(LONG_CYCLES);
    localparam logic [LNG_W-1:0] LNG_PRE = LNG_W'(LONG_CYCLES - 1);

    logic             w_enter_high;
    logic             w_held;
    logic [LNG_W-1:0] r_lcnt;
    logic             r_long;

    // Only a qualified press counts as a new press; an aborted release
    // (S_CHK_LOW back to S_HIGH) keeps the running count.
    assign w_enter_high = (r_state == S_CHK_HIGH) && r_sync_p1 && (r_cnt == CNT_MAX);
    assign w_held       = (r_state == S_HIGH) || (r_state == S_CHK_LOW);

    // Saturation at LNG_MAX is what stops a second pulse within one press.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_lcnt <= '0;
            r_long <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (w_enter_high) begin
                r_lcnt <= '0;
            end else if (w_held && (r_lcnt != LNG_MAX)) begin
                r_lcnt <= r_lcnt + LNG_W'(1);
                if (r_lcnt == LNG_PRE) begin
                    r_long <= 1'b1;
                end
            end
        end
    end

    assign bus.o_long = r_long;
`else
    assign bus.o_long = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// ---------------------------------------------------------------------------
// tb_btn_debounce
//   Directed bench for btn_debounce with DEB_CYCLES=4, LONG_CYCLES=10.
//   Inputs change 1 time unit after a rising edge; outputs are sampled at the
//   same point, so after "tick" number k the k-th edge since the last input
//   change has been applied. A clean step is accepted at k = 7.
// ---------------------------------------------------------------------------
module tb_btn_debounce;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;

    btn_debounce_if bus ();

    btn_debounce #(
        .DEB_CYCLES  (4),
        .LONG_CYCLES (10)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reset holds everything low, then a steady high is accepted at edge 7.
    task automatic test_reset;
        logic exp;
        rstn       = 1'b0;
        bus.i_din  = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (bus.o_dout !== 1'b0) begin n_fail++; $display("FAIL reset_dout got=%b exp=0", bus.o_dout); end
        n_tests++;
        if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
        n_tests++;
        if (bus.o_long !== 1'b0) begin n_fail++; $display("FAIL reset_long got=%b exp=0", bus.o_long); end
        rstn = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp = (k == 7);
            n_tests++;
            if (bus.o_dout !== exp) begin n_fail++; $display("FAIL rise_dout k=%0d got=%b exp=%b", k, bus.o_dout, exp); end
            exp = (k >= 3) && (k <= 6);
            n_tests++;
            if (bus.o_busy !== exp) begin n_fail++; $display("FAIL rise_busy k=%0d got=%b exp=%b", k, bus.o_busy, exp); end
        end
    endtask

    // Two-clock low glitch while high is rejected; a steady low is accepted.
    task automatic test_release;
        logic exp;
        for (int k = 1; k <= 12; k++) begin
            bus.i_din = (k <= 2) ? 1'b0 : 1'b1;
            tick();
            n_tests++;
            if (bus.o_dout !== 1'b1) begin n_fail++; $display("FAIL glitch_dout k=%0d got=%b exp=1", k, bus.o_dout); end
            exp = (k == 3) || (k == 4);
            n_tests++;
            if (bus.o_busy !== exp) begin n_fail++; $display("FAIL glitch_busy k=%0d got=%b exp=%b", k, bus.o_busy, exp); end
        end
        bus.i_din = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp = (k < 7);
            n_tests++;
            if (bus.o_dout !== exp) begin n_fail++; $display("FAIL fall_dout k=%0d got=%b exp=%b", k, bus.o_dout, exp); end
            exp = (k >= 3) && (k <= 6);
            n_tests++;
            if (bus.o_busy !== exp) begin n_fail++; $display("FAIL fall_busy k=%0d got=%b exp=%b", k, bus.o_busy, exp); end
        end
    endtask

    // 1,1,1,0 then steady 1: qualification aborts once, restarts, rises once.
    task automatic test_bounce;
        logic exp;
        int   falls;
        for (int k = 1; k <= 11; k++) begin
            bus.i_din = (k == 4) ? 1'b0 : 1'b1;
            tick();
            exp = (k == 11);
            n_tests++;
            if (bus.o_dout !== exp) begin n_fail++; $display("FAIL bounce_dout k=%0d got=%b exp=%b", k, bus.o_dout, exp); end
            exp = ((k >= 3) && (k <= 5)) || ((k >= 7) && (k <= 10));
            n_tests++;
            if (bus.o_busy !== exp) begin n_fail++; $display("FAIL bounce_busy k=%0d got=%b exp=%b", k, bus.o_busy, exp); end
        end
        falls = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bus.o_dout !== 1'b1) falls++;
        end
        n_tests++;
        if (falls !== 0) begin n_fail++; $display("FAIL bounce_single_rise low_cycles=%0d exp=0", falls); end
    endtask

    // Asynchronous reset during both qualification directions.
    task automatic test_reset_mid;
        logic exp;
        bus.i_din = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL mid_chklow_busy got=%b exp=1", bus.o_busy); end
        n_tests++;
        if (bus.o_dout !== 1'b1) begin n_fail++; $display("FAIL mid_chklow_dout got=%b exp=1", bus.o_dout); end
        rstn = 1'b0;
        #2;
        n_tests++;
        if (bus.o_dout !== 1'b0) begin n_fail++; $display("FAIL mid_async_dout got=%b exp=0", bus.o_dout); end
        n_tests++;
        if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL mid_async_busy got=%b exp=0", bus.o_busy); end
        bus.i_din = 1'b1;
        repeat (2) tick();
        rstn = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL mid_chkhigh_busy got=%b exp=1", bus.o_busy); end
        rstn = 1'b0;
        #2;
        n_tests++;
        if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL mid_chkhigh_async_busy got=%b exp=0", bus.o_busy); end
        tick();
        rstn = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp = (k == 7);
            n_tests++;
            if (bus.o_dout !== exp) begin n_fail++; $display("FAIL mid_requal_dout k=%0d got=%b exp=%b", k, bus.o_dout, exp); end
            exp = (k >= 3) && (k <= 6);
            n_tests++;
            if (bus.o_busy !== exp) begin n_fail++; $display("FAIL mid_requal_busy k=%0d got=%b exp=%b", k, bus.o_busy, exp); end
        end
    endtask

    // Entered right after o_dout rose: o_long once, 10 clocks later, then never.
    task automatic test_long_press;
        logic exp;
        for (int k = 1; k <= 60; k++) begin
            tick();
            exp = LONG_EN && (k == 10);
            n_tests++;
            if (bus.o_long !== exp) begin n_fail++; $display("FAIL long_pulse k=%0d got=%b exp=%b", k, bus.o_long, exp); end
            n_tests++;
            if (bus.o_dout !== 1'b1) begin n_fail++; $display("FAIL long_dout k=%0d got=%b exp=1", k, bus.o_dout); end
        end
    endtask

    // Press held 9 clocks in total (one short of LONG_CYCLES): no o_long.
    task automatic test_short_press;
        logic exp;
        bus.i_din = 1'b0;
        repeat (7) tick();
        n_tests++;
        if (bus.o_dout !== 1'b0) begin n_fail++; $display("FAIL short_pre_dout got=%b exp=0", bus.o_dout); end
        bus.i_din = 1'b1;
        repeat (7) tick();
        n_tests++;
        if (bus.o_dout !== 1'b1) begin n_fail++; $display("FAIL short_rise_dout got=%b exp=1", bus.o_dout); end
        for (int k = 1; k <= 30; k++) begin
            bus.i_din = (k <= 2) ? 1'b1 : 1'b0;
            tick();
            exp = (k < 9);
            n_tests++;
            if (bus.o_dout !== exp) begin n_fail++; $display("FAIL short_dout k=%0d got=%b exp=%b", k, bus.o_dout, exp); end
            n_tests++;
            if (bus.o_long !== 1'b0) begin n_fail++; $display("FAIL short_long k=%0d got=%b exp=0", k, bus.o_long); end
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rstn      = 1'b0;
        bus.i_din = 1'b0;
        test_reset();
        test_release();
        test_bounce();
        test_reset_mid();
        test_long_press();
        test_short_press();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
